// File: rtl/gpio_reg_arb_pkg.sv
// Shared types for the gpio register-bus arbiter: FSM states, reg-bus structs, index width helper.
package gpio_reg_arb_pkg;

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  // Index width for n items; a single item still gets one bit so ports never collapse.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpio_reg_arb_rr_pick.sv
// Combinational rotate-priority picker: first set bit of valid searching from ptr upward, wrapping.
module gpio_reg_arb_rr_pick
  import gpio_reg_arb_pkg::*;
#(
  parameter int NumReq = 2,
  parameter int IdxW   = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] valid,
  input  logic [IdxW-1:0]   ptr,
  output logic [IdxW-1:0]   idx,
  output logic              found
);

  int j;

  // Scan from the farthest slot back to ptr so the closest requester overwrites earlier hits.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NumReq) j = j - NumReq;
      if (valid[IdxW'(j)]) begin
        idx   = IdxW'(j);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_reg_arbiter.sv
// Round-robin arbiter sharing one gpio register-bus target among NumReq requesters.
// Optional BUSY timeout with forced error response when GPIO_REG_ARB_TIMEOUT_EN is defined.
module gpio_reg_arbiter
  import gpio_reg_arb_pkg::*;
#(
  parameter int NumReq        = 2,
  parameter int TimeoutCycles = 256
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  reg_req_t [NumReq-1:0]         req_i,
  output reg_rsp_t [NumReq-1:0]         rsp_o,
  output reg_req_t                      slv_req_o,
  input  reg_rsp_t                      slv_rsp_i,
  output logic [idx_width(NumReq)-1:0]  gnt_idx_o,
  output logic                          busy_o
);

  localparam int IdxW = idx_width(NumReq);

  if (NumReq < 1 || TimeoutCycles < 2) begin : g_param_check
    $error("gpio_reg_arbiter: NumReq must be >= 1 and TimeoutCycles >= 2");
  end

  state_e            state;
  logic [IdxW-1:0]   ptr;
  logic [IdxW-1:0]   gnt;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_found;
  logic [NumReq-1:0] req_valid;
  logic              timeout;
  logic              done;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NumReq; i++) req_valid[i] = req_i[i].valid;
  end

  gpio_reg_arb_rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

`ifdef GPIO_REG_ARB_TIMEOUT_EN
  localparam int CntW = idx_width(TimeoutCycles);
  logic [CntW-1:0] cnt;

  // Held at zero while idle, so the first BUSY cycle always counts from 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else if (!slv_rsp_i.ready) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign timeout = (state == BUSY) && (cnt == CntW'(TimeoutCycles - 1));
`else
  assign timeout = 1'b0;
`endif

  assign done = (state == BUSY) && (slv_rsp_i.ready || timeout);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      slv_req_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            slv_req_o       <= req_i[pick_idx];
            slv_req_o.valid <= 1'b1;
            gnt             <= pick_idx;
            state           <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            slv_req_o.valid <= 1'b0;
            ptr             <= (gnt == IdxW'(NumReq - 1)) ? '0 : gnt + 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Only the granted port sees the target response; a timeout overrides it with an error.
  always_comb begin
    rsp_o = '0;
    if (state == BUSY) begin
      rsp_o[gnt] = slv_rsp_i;
      if (timeout && !slv_rsp_i.ready) begin
        rsp_o[gnt].rdata = '0;
        rsp_o[gnt].error = 1'b1;
        rsp_o[gnt].ready = 1'b1;
      end
    end
  end

  assign gnt_idx_o = gnt;
  assign busy_o    = (state == BUSY);

endmodule

// File: tb/tb_gpio_reg_arbiter.sv
// Directed bench for gpio_reg_arbiter: a 2-port instance and a 3-port instance with TimeoutCycles=8.
module tb_gpio_reg_arbiter;
  import gpio_reg_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst2, rst3;
  reg_req_t [1:0]      req2;
  reg_rsp_t [1:0]      rsp2;
  reg_req_t            slv_req2;
  reg_rsp_t            slv_rsp2;
  logic [0:0]          gnt2;
  logic                busy2;

  reg_req_t [2:0]      req3;
  reg_rsp_t [2:0]      rsp3;
  reg_req_t            slv_req3;
  reg_rsp_t            slv_rsp3;
  logic [1:0]          gnt3;
  logic                busy3;

  int n_assert = 0;
  int n_fail   = 0;

  gpio_reg_arbiter #(.NumReq(2), .TimeoutCycles(256)) d2 (
    .clk_i(clk), .rst_i(rst2), .req_i(req2), .rsp_o(rsp2),
    .slv_req_o(slv_req2), .slv_rsp_i(slv_rsp2), .gnt_idx_o(gnt2), .busy_o(busy2)
  );

  gpio_reg_arbiter #(.NumReq(3), .TimeoutCycles(8)) d3 (
    .clk_i(clk), .rst_i(rst3), .req_i(req3), .rsp_o(rsp3),
    .slv_req_o(slv_req3), .slv_rsp_i(slv_rsp3), .gnt_idx_o(gnt3), .busy_o(busy3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst2 = 1'b1; rst3 = 1'b1;
    req2 = '0; req3 = '0; slv_rsp2 = '0; slv_rsp3 = '0;
    step(); step();
    rst2 = 1'b0; rst3 = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy2", busy2, 0);
    chk("rst_slv_valid2", slv_req2.valid, 0);
    chk("rst_slv_addr2", slv_req2.addr, 0);
    chk("rst_rsp2_0", rsp2[0], 0);
    chk("rst_rsp2_1", rsp2[1], 0);
    chk("rst_gnt2", gnt2, 0);
    chk("rst_busy3", busy3, 0);
    chk("rst_gnt3", gnt3, 0);

    // 1: single write on port0, target ready in its first cycle
    req2[0] = '{addr:32'h04, write:1'b1, wdata:32'hA5, wstrb:4'hF, valid:1'b1};
    slv_rsp2 = '{rdata:32'h0, error:1'b0, ready:1'b1};
    step();
    @(negedge clk);
    chk("t1_busy", busy2, 1);
    chk("t1_slv_valid", slv_req2.valid, 1);
    chk("t1_slv_addr", slv_req2.addr, 32'h04);
    chk("t1_slv_wdata", slv_req2.wdata, 32'hA5);
    chk("t1_slv_wstrb", slv_req2.wstrb, 4'hF);
    chk("t1_slv_write", slv_req2.write, 1);
    chk("t1_rsp0_ready", rsp2[0].ready, 1);
    chk("t1_rsp1_zero", rsp2[1], 0);
    step();
    req2[0] = '0; slv_rsp2 = '0;
    @(negedge clk);
    chk("t1_busy_after", busy2, 0);
    chk("t1_slv_valid_after", slv_req2.valid, 0);
    chk("t1_rsp0_after", rsp2[0], 0);

    // 2: three ports always valid, target always ready -> strict rotation, one txn per 2 cycles
    for (int i = 0; i < 3; i++)
      req3[i] = '{addr:32'h10 + 32'(4 * i), write:1'b1, wdata:32'(i), wstrb:4'hF, valid:1'b1};
    slv_rsp3 = '{rdata:32'h0, error:1'b0, ready:1'b1};
    for (int g = 0; g < 6; g++) begin
      step();
      @(negedge clk);
      chk($sformatf("t2_busy_%0d", g), busy3, 1);
      chk($sformatf("t2_gnt_%0d", g), gnt3, 64'(g % 3));
      chk($sformatf("t2_addr_%0d", g), slv_req3.addr, 64'(32'h10 + 4 * (g % 3)));
      chk($sformatf("t2_ready_%0d", g), rsp3[g % 3].ready, 1);
      step();
      @(negedge clk);
      chk($sformatf("t2_idle_%0d", g), busy3, 0);
    end
    req3 = '0; slv_rsp3 = '0;

    // 3: read on port1 with 5 wait cycles while port0 also requests (pointer is 1 here)
    req2[0] = '{addr:32'h0C, write:1'b1, wdata:32'h77, wstrb:4'h3, valid:1'b1};
    req2[1] = '{addr:32'h08, write:1'b0, wdata:32'h0, wstrb:4'h0, valid:1'b1};
    step();
    for (int w = 0; w < 5; w++) begin
      @(negedge clk);
      chk($sformatf("t3_gnt_w%0d", w), gnt2, 1);
      chk($sformatf("t3_valid_w%0d", w), slv_req2.valid, 1);
      chk($sformatf("t3_addr_w%0d", w), slv_req2.addr, 32'h08);
      chk($sformatf("t3_write_w%0d", w), slv_req2.write, 0);
      chk($sformatf("t3_rsp1_w%0d", w), rsp2[1].ready, 0);
      chk($sformatf("t3_rsp0_w%0d", w), rsp2[0], 0);
      step();
    end
    slv_rsp2 = '{rdata:32'hDEADBEEF, error:1'b0, ready:1'b1};
    #1;
    chk("t3_rdata", rsp2[1].rdata, 32'hDEADBEEF);
    chk("t3_ready", rsp2[1].ready, 1);
    chk("t3_rsp0_zero", rsp2[0], 0);
    step();
    req2[1] = '0; slv_rsp2 = '0;
    @(negedge clk);
    chk("t3_idle", busy2, 0);
    step();
    @(negedge clk);
    chk("t3_port0_gnt", gnt2, 0);
    chk("t3_port0_addr", slv_req2.addr, 32'h0C);
    slv_rsp2 = '{rdata:32'h0, error:1'b0, ready:1'b1};
    step();
    req2[0] = '0; slv_rsp2 = '0;

    // 4: reset mid-transaction (pointer is 1 before reset)
    req2[1] = '{addr:32'h20, write:1'b0, wdata:32'h0, wstrb:4'h0, valid:1'b1};
    step();
    @(negedge clk);
    chk("t4_gnt_before", gnt2, 1);
    chk("t4_busy_before", busy2, 1);
    slv_rsp2 = '{rdata:32'h99, error:1'b0, ready:1'b1};
    rst2 = 1'b1;
    #1;
    chk("t4_slv_valid_rst", slv_req2.valid, 0);
    chk("t4_busy_rst", busy2, 0);
    chk("t4_rsp1_rst", rsp2[1], 0);
    chk("t4_gnt_rst", gnt2, 0);
    req2 = '0; slv_rsp2 = '0;
    #1;
    rst2 = 1'b0;
    req2[0] = '{addr:32'h30, write:1'b1, wdata:32'h1, wstrb:4'h1, valid:1'b1};
    req2[1] = '{addr:32'h34, write:1'b1, wdata:32'h2, wstrb:4'h1, valid:1'b1};
    step();
    @(negedge clk);
    chk("t4_ptr0_gnt", gnt2, 0);
    chk("t4_ptr0_addr", slv_req2.addr, 32'h30);
    slv_rsp2 = '{rdata:32'h0, error:1'b0, ready:1'b1};
    step();
    req2 = '0; slv_rsp2 = '0;

    // 5: target never ready on port1 read
    req3[1] = '{addr:32'h40, write:1'b0, wdata:32'h0, wstrb:4'h0, valid:1'b1};
    slv_rsp3 = '{rdata:32'h1234, error:1'b0, ready:1'b0};
    step();
`ifdef GPIO_REG_ARB_TIMEOUT_EN
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("t5_wait_ready_%0d", c), rsp3[1].ready, 0);
      chk($sformatf("t5_wait_busy_%0d", c), busy3, 1);
      step();
    end
    @(negedge clk);
    chk("t5_timeout_rsp", rsp3[1], {32'h0, 1'b1, 1'b1});
    chk("t5_timeout_rsp0", rsp3[0], 0);
    step();
    req3 = '0; slv_rsp3 = '0;
    @(negedge clk);
    chk("t5_idle_after", busy3, 0);
    chk("t5_slv_valid_after", slv_req3.valid, 0);
`else
    repeat (1000) step();
    @(negedge clk);
    chk("t5_still_busy", busy3, 1);
    chk("t5_no_ready", rsp3[1].ready, 0);
    chk("t5_slv_valid", slv_req3.valid, 1);
    rst3 = 1'b1;
    req3 = '0; slv_rsp3 = '0;
    #1;
    rst3 = 1'b0;
`endif

    // 6: target error forwarded to granted port only; pointer wraps 2 -> 0
    req3[2] = '{addr:32'h48, write:1'b1, wdata:32'h5, wstrb:4'hF, valid:1'b1};
    slv_rsp3 = '{rdata:32'h55, error:1'b1, ready:1'b1};
    step();
    @(negedge clk);
    chk("t6_gnt", gnt3, 2);
    chk("t6_rsp2", rsp3[2], {32'h55, 1'b1, 1'b1});
    chk("t6_rsp0_zero", rsp3[0], 0);
    chk("t6_rsp1_zero", rsp3[1], 0);
    step();
    for (int i = 0; i < 3; i++)
      req3[i] = '{addr:32'h50 + 32'(4 * i), write:1'b0, wdata:32'h0, wstrb:4'h0, valid:1'b1};
    slv_rsp3 = '{rdata:32'h0, error:1'b0, ready:1'b1};
    step();
    @(negedge clk);
    chk("t6_wrap_gnt", gnt3, 0);
    chk("t6_wrap_addr", slv_req3.addr, 32'h50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
